// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: streams a program in, then serves word-aligned fetches until done.
// Optional cycle counter output enabled by defining INSTR_MEM_CYCLE_COUNT_EN.
module instr_mem_ctrl #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 1024,
  localparam int ADDR_W           = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  input  logic                         run,
  input  logic [DATA_WIDTH-1:0]        programCounter,
  output logic [INSTRUCTION_WIDTH-1:0] memoryOut,
  output logic                         fetch_valid,
  output logic                         done,
  output logic                         fault,
  output logic [ADDR_W:0]              programLength
`ifdef INSTR_MEM_CYCLE_COUNT_EN
  ,
  output logic [31:0]                  cycles
`endif
);

  typedef enum logic [1:0] {StLoad, StIdle, StRun, StDone} state_e;

  state_e                       state;
  logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]            wrPtr;
  logic [DATA_WIDTH-1:0]        wordIdx;
  logic                         misaligned;
  logic                         pastEnd;
  logic                         loadAccept;
  logic                         lastWord;

  assign load_ready = (state == StLoad);
  assign loadAccept = load_ready && load_valid;
  assign lastWord   = load_last || (wrPtr == ADDR_W'(DEPTH - 1));

  // Full-width compare so a PC beyond the array terminates instead of aliasing.
  assign wordIdx    = programCounter >> 2;
  assign misaligned = |programCounter[1:0];
  assign pastEnd    = wordIdx >= DATA_WIDTH'(programLength);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (loadAccept) begin
      mem[wrPtr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= StLoad;
      wrPtr         <= '0;
      programLength <= '0;
      memoryOut     <= '0;
      fetch_valid   <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      unique case (state)
        StLoad: begin
          if (load_valid) begin
            wrPtr <= wrPtr + ADDR_W'(1);
            if (lastWord) begin
              programLength <= {1'b0, wrPtr} + (ADDR_W + 1)'(1);
              state         <= StIdle;
            end
          end
        end
        StIdle: begin
          if (run) begin
            state <= StRun;
          end
        end
        StRun: begin
          if (misaligned) begin
            fault       <= 1'b1;
            done        <= 1'b1;
            fetch_valid <= 1'b0;
            memoryOut   <= '0;
            state       <= StDone;
          end else if (pastEnd) begin
            done        <= 1'b1;
            fetch_valid <= 1'b0;
            memoryOut   <= '0;
            state       <= StDone;
          end else begin
            memoryOut   <= mem[wordIdx[ADDR_W-1:0]];
            fetch_valid <= 1'b1;
          end
        end
        StDone: begin
          done        <= 1'b1;
          fetch_valid <= 1'b0;
          memoryOut   <= '0;
        end
        default: state <= StLoad;
      endcase
    end
  end

`ifdef INSTR_MEM_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (state == StRun && cycles != '1) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl (DEPTH=8): load, fetch, termination, fault and async reset.
module tb_instr_mem_ctrl;

  localparam int IW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          run = 1'b0;
  logic [DW-1:0] programCounter = '0;
  logic [IW-1:0] memoryOut;
  logic          fetch_valid;
  logic          done;
  logic          fault;
  logic [3:0]    programLength;
`ifdef INSTR_MEM_CYCLE_COUNT_EN
  logic [31:0]   cycles;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(
    .INSTRUCTION_WIDTH(IW),
    .DATA_WIDTH       (DW),
    .DEPTH            (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .run           (run),
    .programCounter(programCounter),
    .memoryOut     (memoryOut),
    .fetch_valid   (fetch_valid),
    .done          (done),
    .fault         (fault),
    .programLength (programLength)
`ifdef INSTR_MEM_CYCLE_COUNT_EN
    ,
    .cycles        (cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [IW-1:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [DW-1:0] pc);
    programCounter = pc;
    tick();
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic startRun();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] wordsA [4];
    logic [IW-1:0] wordsB [4];
    logic [IW-1:0] wordsC [8];
    for (int i = 0; i < 4; i++) begin
      wordsA[i] = 32'hA0A0_0000 + 32'(i);
      wordsB[i] = 32'hB0B0_1000 + 32'(i);
    end
    for (int i = 0; i < 8; i++) wordsC[i] = 32'hC0C0_2000 + 32'(i * 17);

    // Reset state while reset is held low
    #2;
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_len", 64'(programLength), 64'd0);
    check("rst_fv", 64'(fetch_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_mem_out", 64'(memoryOut), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Four-word program, explicit last
    for (int i = 0; i < 4; i++) loadWord(wordsA[i], i == 3);
    check("a_len", 64'(programLength), 64'd4);
    check("a_ready_idle", 64'(load_ready), 64'd0);
    loadWord(32'hDEAD_BEEF, 1'b1);
    check("a_len_after_ignored", 64'(programLength), 64'd4);

    startRun();
    check("a_ready_run", 64'(load_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(DW'(i * 4));
      check($sformatf("a_word%0d", i), 64'(memoryOut), 64'(wordsA[i]));
      check($sformatf("a_fv%0d", i), 64'(fetch_valid), 64'd1);
    end
    fetch(32'd16);
    check("a_end_done", 64'(done), 64'd1);
    check("a_end_fv", 64'(fetch_valid), 64'd0);
    check("a_end_out", 64'(memoryOut), 64'd0);
    check("a_end_fault", 64'(fault), 64'd0);
`ifdef INSTR_MEM_CYCLE_COUNT_EN
    check("a_cycles", 64'(cycles), 64'd5);
`endif
    run = 1'b1;
    fetch(32'd0);
    run = 1'b0;
    check("a_hold_done", 64'(done), 64'd1);
    check("a_hold_fv", 64'(fetch_valid), 64'd0);
    check("a_hold_out", 64'(memoryOut), 64'd0);
`ifdef INSTR_MEM_CYCLE_COUNT_EN
    check("a_cycles_frozen", 64'(cycles), 64'd5);
`endif

    // Misaligned fetch
    doReset();
    check("b_ready_after_rst", 64'(load_ready), 64'd1);
    check("b_len_after_rst", 64'(programLength), 64'd0);
    for (int i = 0; i < 4; i++) loadWord(wordsB[i], i == 3);
    startRun();
    fetch(32'd4);
    check("b_word1", 64'(memoryOut), 64'(wordsB[1]));
    fetch(32'd6);
    check("b_fault", 64'(fault), 64'd1);
    check("b_fault_done", 64'(done), 64'd1);
    check("b_fault_out", 64'(memoryOut), 64'd0);
    check("b_fault_fv", 64'(fetch_valid), 64'd0);
    fetch(32'd0);
    check("b_fault_sticky", 64'(fault), 64'd1);
    check("b_done_sticky", 64'(done), 64'd1);
    check("b_out_sticky", 64'(memoryOut), 64'd0);

    // Full-depth load without load_last; PC past DEPTH*4 must terminate
    doReset();
    for (int i = 0; i < 8; i++) loadWord(wordsC[i], 1'b0);
    check("c_len", 64'(programLength), 64'd8);
    check("c_ready_idle", 64'(load_ready), 64'd0);
    loadWord(32'h5555_AAAA, 1'b0);
    check("c_len_9th", 64'(programLength), 64'd8);
    startRun();
    fetch(32'd0);
    check("c_word0_intact", 64'(memoryOut), 64'(wordsC[0]));
    fetch(32'd28);
    check("c_word7", 64'(memoryOut), 64'(wordsC[7]));
    check("c_word7_fv", 64'(fetch_valid), 64'd1);
    fetch(32'd32);
    check("c_alias_done", 64'(done), 64'd1);
    check("c_alias_out", 64'(memoryOut), 64'd0);
    check("c_alias_fault", 64'(fault), 64'd0);

    // High PC bit with an in-range low index must terminate too
    doReset();
    for (int i = 0; i < 4; i++) loadWord(wordsA[i], i == 3);
    startRun();
    fetch(32'h8000_0004);
    check("d_high_pc_done", 64'(done), 64'd1);
    check("d_high_pc_fv", 64'(fetch_valid), 64'd0);

    // Async reset mid-RUN
    doReset();
    for (int i = 0; i < 4; i++) loadWord(wordsB[i], i == 3);
    startRun();
    fetch(32'd0);
    fetch(32'd8);
    check("e_word2", 64'(memoryOut), 64'(wordsB[2]));
    #3;
    reset = 1'b0;
    #1;
    check("e_async_out", 64'(memoryOut), 64'd0);
    check("e_async_fv", 64'(fetch_valid), 64'd0);
    check("e_async_done", 64'(done), 64'd0);
    check("e_async_fault", 64'(fault), 64'd0);
    check("e_async_len", 64'(programLength), 64'd0);
    check("e_async_ready", 64'(load_ready), 64'd1);
`ifdef INSTR_MEM_CYCLE_COUNT_EN
    check("e_async_cycles", 64'(cycles), 64'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    check("e_post_ready", 64'(load_ready), 64'd1);
    loadWord(wordsA[0], 1'b1);
    check("e_reload_len", 64'(programLength), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
